mem_access_unit: RTL and testbench

Sequences every data-memory access for the multicycle datapath. It sits directly upstream of the load-size extractor and owns the Memory Data register that feeds it. Loads are issued as a timed read, and the raw 32-bit word is captured into `mdr`. Halfword and byte stores are performed as a read-modify-write, merging the low bits of the store operand into the word currently at the address; word stores write directly.

---
 rtl/mem_access_unit.sv | 116 +++++++++++
 tb/tb_mem_access_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - data-memory access sequencer with timed reads, read-modify-write sub-word stores and MDR
module mem_access_unit #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mdr,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [1:0] SZ_WORD  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_INVAL = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic [31:0] sdata_q, sdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] mdr_q, mdr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      sdata_q <= '0;
      cnt_q   <= '0;
      merge_q <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      sdata_q <= sdata_d;
      cnt_q   <= cnt_d;
      merge_q <= merge_d;
      mdr_q   <= mdr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    sdata_d = sdata_q;
    cnt_d   = cnt_q;
    merge_d = merge_q;
    mdr_d   = mdr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = addr;
          size_d  = size;
          write_d = write;
          sdata_d = store_data;
          cnt_d   = CNT_INIT;
          if (size == SZ_INVAL)
            state_d = S_DONE;
          else if (write && size == SZ_WORD)
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          if (!write_q) begin
            mdr_d   = mem_rdata;
            state_d = S_DONE;
          end else begin
            // Sub-word store: keep the upper bytes of the current word, splice in the operand.
            if (size_q == SZ_HALF)
              merge_d = {mem_rdata[31:16], sdata_q[15:0]};
            else
              merge_d = {mem_rdata[31:8], sdata_q[7:0]};
            state_d = S_WR;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wr    = (state_q == S_WR);
  assign mem_wdata = mem_wr ? ((size_q == SZ_WORD) ? sdata_q : merge_q) : 32'd0;
  assign mdr       = mdr_q;
  assign busy      = (state_q == S_RD) || (state_q == S_WR);
  assign done      = (state_q == S_DONE);
  assign fault     = done && (size_q == SZ_INVAL);

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit at LATENCY 1 and 3
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        start1, start3;
  logic        write;
  logic [1:0]  size;
  logic [31:0] addr, store_data;

  logic [31:0] u1_mem_addr, u1_mem_wdata, u1_mem_rdata, u1_mdr;
  logic        u1_mem_wr, u1_busy, u1_done, u1_fault;
  logic [31:0] u3_mem_addr, u3_mem_wdata, u3_mem_rdata, u3_mdr;
  logic        u3_mem_wr, u3_busy, u3_done, u3_fault;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          inst;
    int          cyc;
    logic        fault;
    logic [31:0] mdr;
  } exp_t;

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  mem_access_unit #(.LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .write(write), .size(size),
    .addr(addr), .store_data(store_data), .mem_addr(u1_mem_addr), .mem_wr(u1_mem_wr),
    .mem_wdata(u1_mem_wdata), .mem_rdata(u1_mem_rdata), .mdr(u1_mdr),
    .busy(u1_busy), .done(u1_done), .fault(u1_fault)
  );

  mem_access_unit #(.LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .write(write), .size(size),
    .addr(addr), .store_data(store_data), .mem_addr(u3_mem_addr), .mem_wr(u3_mem_wr),
    .mem_wdata(u3_mem_wdata), .mem_rdata(u3_mem_rdata), .mdr(u3_mdr),
    .busy(u3_busy), .done(u3_done), .fault(u3_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns real data only in the cycle a read of the given latency samples it.
  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          age1 = 0, age3 = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (u1_mem_wr) mem[u1_mem_addr[5:2]] <= u1_mem_wdata;
    if (u3_mem_wr) mem[u3_mem_addr[5:2]] <= u3_mem_wdata;
    age1 <= (u1_busy && !u1_mem_wr) ? age1 + 1 : 0;
    age3 <= (u3_busy && !u3_mem_wr) ? age3 + 1 : 0;
  end

  assign u1_mem_rdata = (u1_busy && !u1_mem_wr && age1 == 0) ? mem[u1_mem_addr[5:2]] : 32'hBAD0_BAD0;
  assign u3_mem_rdata = (u3_busy && !u3_mem_wr && age3 == 2) ? mem[u3_mem_addr[5:2]] : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_done(input int inst, input logic flt, input logic [31:0] m);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL done_unexpected: inst %0d pulsed done at cyc %0d, none expected", inst, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("done_inst", 32'(inst), 32'(e.inst));
      chk("done_cycle", 32'(cyc), 32'(e.cyc));
      chk("fault", 32'(flt), 32'(e.fault));
      chk("mdr", m, e.mdr);
    end
  endtask

  task automatic check_wr(input int inst, input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    if (wr_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL mem_wr_unexpected: inst %0d wrote %h to %h at cyc %0d", inst, d, a, cyc);
    end else begin
      w = wr_q.pop_front();
      chk("wr_inst", 32'(inst), 32'(w.inst));
      chk("wr_cycle", 32'(cyc), 32'(w.cyc));
      chk("wr_addr", a, w.addr);
      chk("wr_wdata", d, w.wdata);
    end
  endtask

  always @(negedge clk) begin
    if (u1_done) check_done(0, u1_fault, u1_mdr);
    if (u3_done) check_done(1, u3_fault, u3_mdr);
    if (u1_mem_wr) check_wr(0, u1_mem_addr, u1_mem_wdata);
    if (u3_mem_wr) check_wr(1, u3_mem_addr, u3_mem_wdata);
  end

  task automatic push_done(input int inst, input int c, input logic flt, input logic [31:0] m);
    exp_t e;
    e.inst = inst; e.cyc = c; e.fault = flt; e.mdr = m;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input int inst, input int c, input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.inst = inst; w.cyc = c; w.addr = a; w.wdata = d;
    wr_q.push_back(w);
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Returns c such that cycle k after acceptance is seen at negedge as cyc == c + k.
  task automatic issue(input int inst, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] sd, output int c);
    @(negedge clk);
    write = wr; size = sz; addr = a; store_data = sd;
    if (inst == 0) start1 = 1'b1; else start3 = 1'b1;
    c = cyc;
    @(posedge clk);
    #1 start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_u1_mdr", u1_mdr, 32'd0);
    chk("rst_u1_mem_addr", u1_mem_addr, 32'd0);
    chk("rst_u1_mem_wr", 32'(u1_mem_wr), 32'd0);
    chk("rst_u1_mem_wdata", u1_mem_wdata, 32'd0);
    chk("rst_u1_busy", 32'(u1_busy), 32'd0);
    chk("rst_u1_done", 32'(u1_done), 32'd0);
    chk("rst_u1_fault", 32'(u1_fault), 32'd0);
    chk("rst_u3_mdr", u3_mdr, 32'd0);
    chk("rst_u3_mem_addr", u3_mem_addr, 32'd0);
    chk("rst_u3_mem_wr", 32'(u3_mem_wr), 32'd0);
    chk("rst_u3_busy", 32'(u3_busy), 32'd0);
    chk("rst_u3_done", 32'(u3_done), 32'd0);
  endtask

  initial begin
    int c;
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
    write = 1'b0; size = 2'b00; addr = '0; store_data = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;
    preload(4'h4, 32'hDEAD_BEEF);
    preload(4'h8, 32'h1122_3344);

    // Word load, L=1
    issue(0, 1'b0, 2'b00, 32'h10, 32'h0, c);
    push_done(0, c + 2, 1'b0, 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);

    // Byte store, L=1
    issue(0, 1'b1, 2'b10, 32'h20, 32'hAABB_CCDD, c);
    push_wr(0, c + 2, 32'h20, 32'h1122_33DD);
    push_done(0, c + 3, 1'b0, 32'hDEAD_BEEF);
    repeat (5) @(negedge clk);

    // Word load then halfword store, L=3
    issue(1, 1'b0, 2'b00, 32'h10, 32'h0, c);
    push_done(1, c + 4, 1'b0, 32'hDEAD_BEEF);
    repeat (6) @(negedge clk);
    preload(4'h8, 32'h1122_3344);
    issue(1, 1'b1, 2'b01, 32'h20, 32'hAABB_CCDD, c);
    push_wr(1, c + 4, 32'h20, 32'h1122_CCDD);
    push_done(1, c + 5, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("hw_store_busy_rd", 32'(u3_busy), 32'd1);
    repeat (6) @(negedge clk);

    // Word store, L=1
    issue(0, 1'b1, 2'b00, 32'h30, 32'hAABB_CCDD, c);
    push_wr(0, c + 1, 32'h30, 32'hAABB_CCDD);
    push_done(0, c + 2, 1'b0, 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);

    // Invalid size
    issue(0, 1'b0, 2'b11, 32'h10, 32'h0, c);
    push_done(0, c + 1, 1'b1, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    chk("fault_cleared", 32'(u1_fault), 32'd0);
    chk("done_cleared", 32'(u1_done), 32'd0);
    repeat (2) @(negedge clk);

    // Reset while the byte store is in WR
    preload(4'h8, 32'h1122_3344);
    issue(0, 1'b1, 2'b10, 32'h20, 32'hAABB_CCDD, c);
    @(posedge clk);
    #1 chk("abort_in_wr", 32'(u1_mem_wr), 32'd1);
    reset = 1'b1;
    #1 chk_reset_outputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue(0, 1'b0, 2'b00, 32'h20, 32'h0, c);
    push_done(0, c + 2, 1'b0, 32'h1122_3344);
    repeat (4) @(negedge clk);

    // start held high across two loads; addr change during RD must not affect the first
    @(negedge clk);
    write = 1'b0; size = 2'b00; addr = 32'h10; start1 = 1'b1;
    c = cyc;
    push_done(0, c + 2, 1'b0, 32'hDEAD_BEEF);
    push_done(0, c + 5, 1'b0, 32'h1122_3344);
    @(negedge clk);
    addr = 32'h20;
    chk("held_busy_rd1", 32'(u1_busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("held_idle_busy", 32'(u1_busy), 32'd0);
    chk("held_idle_done", 32'(u1_done), 32'd0);
    @(negedge clk);
    chk("held_busy_rd2", 32'(u1_busy), 32'd1);
    start1 = 1'b0;
    repeat (4) @(negedge clk);

    chk("pending_done", 32'(exp_q.size()), 32'd0);
    chk("pending_wr", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
